// File: rtl/qpu_exu_alu_rglr_pipe.sv
// qpu_exu_alu_rglr_pipe: registered QPU regular ALU with a one-entry skid buffer.
// One op per cycle over valid/ready; results leave in FIFO order from the main register.
module qpu_exu_alu_rglr_pipe #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned TIME_WIDTH = 32,
    parameter int unsigned QMR_NUM    = 8,
    parameter int unsigned TAG_W      = 5
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_valid,
    output logic                  i_ready,
    input  logic [XLEN-1:0]       i_rs1,
    input  logic [XLEN-1:0]       i_rs2,
    input  logic [XLEN-1:0]       i_imm,
    input  logic [TIME_WIDTH-1:0] i_clk,
    input  logic [QMR_NUM-1:0]    i_qmr,
    input  logic [3:0]            i_op,
    input  logic [1:0]            i_op1sel,
    input  logic                  i_op2imm,
    input  logic [TAG_W-1:0]      i_tag,
    output logic                  o_valid,
    input  logic                  o_ready,
    output logic [XLEN-1:0]       o_wdata,
    output logic [TAG_W-1:0]      o_tag,
    output logic                  o_ovf,
    output logic                  o_illegal
);

    localparam int unsigned QIDX = $clog2(QMR_NUM);
    localparam int unsigned SHW  = $clog2(XLEN);

    localparam logic [3:0] OP_ADD   = 4'd0;
    localparam logic [3:0] OP_SUB   = 4'd1;
    localparam logic [3:0] OP_XOR   = 4'd2;
    localparam logic [3:0] OP_OR    = 4'd3;
    localparam logic [3:0] OP_AND   = 4'd4;
    localparam logic [3:0] OP_SLL   = 4'd5;
    localparam logic [3:0] OP_SRL   = 4'd6;
    localparam logic [3:0] OP_SRA   = 4'd7;
    localparam logic [3:0] OP_SLT   = 4'd8;
    localparam logic [3:0] OP_SLTU  = 4'd9;
    localparam logic [3:0] OP_PASS2 = 4'd10;

    localparam logic [1:0] SEL_RS1  = 2'd0;
    localparam logic [1:0] SEL_ZERO = 2'd1;
    localparam logic [1:0] SEL_CLK  = 2'd2;
    localparam logic [1:0] SEL_QMR  = 2'd3;

    // Result entry as held in the main and skid registers.
    typedef struct packed {
        logic [XLEN-1:0]  wdata;
        logic [TAG_W-1:0] tag;
        logic             ovf;
        logic             illegal;
    } entry_t;

    logic [XLEN-1:0] op_a;
    logic [XLEN-1:0] op_b;
    logic [SHW-1:0]  shamt;
    logic [XLEN-1:0] add_res;
    logic [XLEN-1:0] sub_res;
    entry_t          new_entry;

    entry_t main_q, main_d;
    entry_t skid_q, skid_d;
    logic   main_vld_q, main_vld_d;
    logic   skid_vld_q, skid_vld_d;
    logic   rdy_q, rdy_d;

    logic accept;
    logic drain;

    // Operand selection and ALU function for the incoming op.
    always_comb begin
        op_a      = '0;
        op_b      = i_op2imm ? i_imm : i_rs2;
        new_entry = '0;

        unique case (i_op1sel)
            SEL_RS1:  op_a = i_rs1;
            SEL_ZERO: op_a = '0;
            SEL_CLK:  op_a = XLEN'(i_clk);
            SEL_QMR:  op_a = XLEN'(i_qmr[i_rs1[QIDX-1:0]]);
            default:  op_a = '0;
        endcase

        shamt   = op_b[SHW-1:0];
        add_res = op_a + op_b;
        sub_res = op_a - op_b;

        new_entry.tag = i_tag;
        case (i_op)
            OP_ADD: begin
                new_entry.wdata = add_res;
                new_entry.ovf   = (op_a[XLEN-1] == op_b[XLEN-1]) &&
                                  (add_res[XLEN-1] != op_a[XLEN-1]);
            end
            OP_SUB: begin
                new_entry.wdata = sub_res;
                new_entry.ovf   = (op_a[XLEN-1] != op_b[XLEN-1]) &&
                                  (sub_res[XLEN-1] != op_a[XLEN-1]);
            end
            OP_XOR:   new_entry.wdata = op_a ^ op_b;
            OP_OR:    new_entry.wdata = op_a | op_b;
            OP_AND:   new_entry.wdata = op_a & op_b;
            OP_SLL:   new_entry.wdata = op_a << shamt;
            OP_SRL:   new_entry.wdata = op_a >> shamt;
            OP_SRA:   new_entry.wdata = $unsigned($signed(op_a) >>> shamt);
            OP_SLT:   new_entry.wdata = XLEN'($signed(op_a) < $signed(op_b));
            OP_SLTU:  new_entry.wdata = XLEN'(op_a < op_b);
            OP_PASS2: new_entry.wdata = op_b;
            default:  new_entry.illegal = 1'b1;
        endcase
    end

    assign accept = i_valid & rdy_q;
    assign drain  = main_vld_q & o_ready;

    // Main/skid occupancy and data movement; ready is registered from next skid state.
    always_comb begin
        main_d     = main_q;
        skid_d     = skid_q;
        main_vld_d = main_vld_q;
        skid_vld_d = skid_vld_q;

        if (drain && skid_vld_q) begin
            main_d     = skid_q;
            skid_vld_d = 1'b0;
        end else if (!main_vld_q || drain) begin
            if (accept) begin
                main_d     = new_entry;
                main_vld_d = 1'b1;
            end else begin
                main_vld_d = 1'b0;
            end
        end else if (accept) begin
            skid_d     = new_entry;
            skid_vld_d = 1'b1;
        end

        rdy_d = ~skid_vld_d;
    end

    // State registers; reset empties both entries and raises ready.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            main_q     <= '0;
            skid_q     <= '0;
            main_vld_q <= 1'b0;
            skid_vld_q <= 1'b0;
            rdy_q      <= 1'b1;
        end else begin
            main_q     <= main_d;
            skid_q     <= skid_d;
            main_vld_q <= main_vld_d;
            skid_vld_q <= skid_vld_d;
            rdy_q      <= rdy_d;
        end
    end

    assign i_ready   = rdy_q;
    assign o_valid   = main_vld_q;
    assign o_wdata   = main_q.wdata;
    assign o_tag     = main_q.tag;
    assign o_ovf     = main_q.ovf;
    assign o_illegal = main_q.illegal;

endmodule

// File: tb/tb_qpu_exu_alu_rglr_pipe.sv
// Self-checking bench for qpu_exu_alu_rglr_pipe: queue-based reference model plus directed pins.
module tb_qpu_exu_alu_rglr_pipe;

    typedef struct packed {
        logic [31:0] wdata;
        logic [4:0]  tag;
        logic        ovf;
        logic        illegal;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        i_valid = 1'b0;
    logic        i_ready;
    logic [31:0] i_rs1 = '0, i_rs2 = '0, i_imm = '0, i_clk = '0;
    logic [7:0]  i_qmr = '0;
    logic [3:0]  i_op = '0;
    logic [1:0]  i_op1sel = '0;
    logic        i_op2imm = 1'b0;
    logic [4:0]  i_tag = '0;
    logic        o_valid;
    logic        o_ready = 1'b1;
    logic [31:0] o_wdata;
    logic [4:0]  o_tag;
    logic        o_ovf;
    logic        o_illegal;

    int checks = 0;
    int failures = 0;

    exp_t       exp_q[$];
    logic [4:0] dut_tags[$];
    int         or_mode = 0;
    int         bp_idx = 0;
    bit         bp_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    int         low_ready_cnt = 0;

    qpu_exu_alu_rglr_pipe dut (
        .clk(clk), .rst(rst),
        .i_valid(i_valid), .i_ready(i_ready),
        .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm), .i_clk(i_clk), .i_qmr(i_qmr),
        .i_op(i_op), .i_op1sel(i_op1sel), .i_op2imm(i_op2imm), .i_tag(i_tag),
        .o_valid(o_valid), .o_ready(o_ready),
        .o_wdata(o_wdata), .o_tag(o_tag), .o_ovf(o_ovf), .o_illegal(o_illegal)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference ALU from the operation table, using wide signed arithmetic.
    function automatic exp_t model_alu(input logic [3:0] op, input logic [1:0] sel,
                                       input logic [31:0] rs1, input logic [31:0] rs2,
                                       input logic [31:0] imm, input logic [31:0] tclk,
                                       input logic [7:0] qmr, input logic op2imm,
                                       input logic [4:0] tag);
        exp_t        r;
        logic [31:0] a, b;
        longint      sa, sb, s;
        int          sh;
        r = '0;
        r.tag = tag;
        case (sel)
            2'd0:    a = rs1;
            2'd1:    a = 32'd0;
            2'd2:    a = tclk;
            default: a = {31'd0, qmr[rs1[2:0]]};
        endcase
        b  = op2imm ? imm : rs2;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        sh = int'(b % 32);
        case (op)
            4'd0: begin s = sa + sb; r.wdata = 32'(s); r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd1: begin s = sa - sb; r.wdata = 32'(s); r.ovf = (s > 64'sd2147483647) || (s < -64'sd2147483648); end
            4'd2:  r.wdata = a ^ b;
            4'd3:  r.wdata = a | b;
            4'd4:  r.wdata = a & b;
            4'd5:  r.wdata = a << sh;
            4'd6:  r.wdata = a >> sh;
            4'd7:  r.wdata = 32'(sa >>> sh);
            4'd8:  r.wdata = (sa < sb) ? 32'd1 : 32'd0;
            4'd9:  r.wdata = (a < b) ? 32'd1 : 32'd0;
            4'd10: r.wdata = b;
            default: r.illegal = 1'b1;
        endcase
        return r;
    endfunction

    // Model: an in-order queue of at most two pending results.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            bit acc, drn;
            acc = i_valid && (exp_q.size() < 2);
            drn = o_ready && (exp_q.size() > 0);
            if (drn) void'(exp_q.pop_front());
            if (acc) exp_q.push_back(model_alu(i_op, i_op1sel, i_rs1, i_rs2, i_imm,
                                               i_clk, i_qmr, i_op2imm, i_tag));
        end
    end

    // Log of tags actually delivered by the DUT.
    always @(posedge clk) begin
        if (!rst && o_valid && o_ready) dut_tags.push_back(o_tag);
        if (!rst && !i_ready) low_ready_cnt++;
    end

    // Output-ready driver: always high, fixed pattern, random or held low.
    always @(posedge clk) begin
        #1;
        case (or_mode)
            0: o_ready = 1'b1;
            1: begin o_ready = (bp_idx < 7) ? bp_pat[bp_idx] : 1'b1; bp_idx++; end
            2: o_ready = 1'($urandom_range(0, 1));
            default: o_ready = 1'b0;
        endcase
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (rst) begin
            chk("rst_o_valid", o_valid, 0);
            chk("rst_o_wdata", o_wdata, 0);
            chk("rst_o_tag", o_tag, 0);
            chk("rst_o_ovf", o_ovf, 0);
            chk("rst_o_illegal", o_illegal, 0);
            chk("rst_i_ready", i_ready, 1);
        end else begin
            chk("i_ready", i_ready, exp_q.size() < 2);
            chk("o_valid", o_valid, exp_q.size() > 0);
            if (exp_q.size() > 0) begin
                chk("o_wdata", o_wdata, exp_q[0].wdata);
                chk("o_tag", o_tag, exp_q[0].tag);
                chk("o_ovf", o_ovf, exp_q[0].ovf);
                chk("o_illegal", o_illegal, exp_q[0].illegal);
            end
        end
    end

    // Present one op (called #1 after a rising edge) and hold it until accepted.
    task automatic send(input logic [3:0] op, input logic [1:0] sel, input logic [31:0] rs1,
                        input logic [31:0] rs2, input logic [31:0] imm, input logic [31:0] tclk,
                        input logic [7:0] qmr, input logic op2imm, input logic [4:0] tag,
                        output int cyc);
        bit ok;
        i_valid = 1'b1; i_op = op; i_op1sel = sel; i_rs1 = rs1; i_rs2 = rs2; i_imm = imm;
        i_clk = tclk; i_qmr = qmr; i_op2imm = op2imm; i_tag = tag;
        cyc = 0;
        do begin
            ok = i_ready;
            @(posedge clk); #1;
            cyc++;
        end while (!ok && cyc < 100);
        chk("send_accepted", ok, 1);
        i_valid = 1'b0;
    endtask

    task automatic send_rand(input logic [4:0] tag, output int cyc);
        send(4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)), $urandom, $urandom,
             ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 40)) : $urandom,
             $urandom, 8'($urandom), 1'($urandom_range(0, 1)), tag, cyc);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    initial begin
        exp_t r;
        int   cyc, total;

        // Pin the reference model with hand-computed values.
        r = model_alu(4'd0, 2'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd1);
        chk("pin_add_w", r.wdata, 32'h80000000); chk("pin_add_ovf", r.ovf, 1);
        r = model_alu(4'd1, 2'd0, 32'h80000000, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd2);
        chk("pin_sub_w", r.wdata, 32'h7FFFFFFF); chk("pin_sub_ovf", r.ovf, 1);
        r = model_alu(4'd8, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd3);
        chk("pin_slt", r.wdata, 1);
        r = model_alu(4'd9, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd4);
        chk("pin_sltu", r.wdata, 0);
        r = model_alu(4'd0, 2'd2, 32'h0, 32'h0, 32'd3, 32'd100, 8'h0, 1'b1, 5'd5);
        chk("pin_sel_clk", r.wdata, 103);
        r = model_alu(4'd0, 2'd3, 32'h25, 32'h0, 32'd3, 32'd0, 8'b0010_0000, 1'b1, 5'd6);
        chk("pin_sel_qmr", r.wdata, 4);
        r = model_alu(4'd0, 2'd1, 32'h1234, 32'h0, 32'd3, 32'd0, 8'h0, 1'b1, 5'd7);
        chk("pin_sel_zero", r.wdata, 3);
        r = model_alu(4'd7, 2'd0, 32'h80000000, 32'h24, 32'h0, 32'h0, 8'h0, 1'b0, 5'd8);
        chk("pin_sra", r.wdata, 32'hF8000000);
        r = model_alu(4'd12, 2'd0, 32'h5, 32'h6, 32'h0, 32'h0, 8'h0, 1'b0, 5'd9);
        chk("pin_ill_w", r.wdata, 0); chk("pin_ill_flag", r.illegal, 1); chk("pin_ill_tag", r.tag, 9);

        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        idle(1);

        // Directed ops through the DUT.
        send(4'd0, 2'd0, 32'h7FFFFFFF, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd1, cyc);
        send(4'd1, 2'd0, 32'h80000000, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd2, cyc);
        send(4'd8, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd3, cyc);
        send(4'd9, 2'd0, 32'hFFFFFFFF, 32'h1, 32'h0, 32'h0, 8'h0, 1'b0, 5'd4, cyc);
        send(4'd0, 2'd2, 32'h0, 32'h0, 32'd3, 32'd100, 8'h0, 1'b1, 5'd5, cyc);
        send(4'd0, 2'd3, 32'h25, 32'h0, 32'd3, 32'd0, 8'b0010_0000, 1'b1, 5'd6, cyc);
        send(4'd0, 2'd1, 32'h1234, 32'h0, 32'd3, 32'd0, 8'h0, 1'b1, 5'd7, cyc);
        send(4'd7, 2'd0, 32'h80000000, 32'h24, 32'h0, 32'h0, 8'h0, 1'b0, 5'd8, cyc);
        send(4'd12, 2'd0, 32'h5, 32'h6, 32'h0, 32'h0, 8'h0, 1'b0, 5'd9, cyc);
        idle(3);

        // Back-pressure with a fixed o_ready pattern and six back-to-back ops.
        dut_tags.delete();
        low_ready_cnt = 0;
        bp_idx = 0;
        or_mode = 1;
        idle(1);
        for (int t = 0; t < 6; t++) send_rand(5'(t), cyc);
        idle(6);
        chk("bp_count", dut_tags.size(), 6);
        for (int t = 0; t < 6 && t < dut_tags.size(); t++) chk("bp_order", dut_tags[t], t);
        chk("bp_skid_used", low_ready_cnt > 0, 1);
        or_mode = 0;
        idle(2);

        // Full throughput: one accept per cycle with o_ready held high.
        dut_tags.delete();
        total = 0;
        for (int t = 0; t < 64; t++) begin
            send_rand(5'(t), cyc);
            total += cyc;
        end
        idle(2);
        chk("tput_cycles", total, 64);
        chk("tput_results", dut_tags.size(), 64);

        // Random mix with random o_ready and idle gaps.
        or_mode = 2;
        for (int t = 0; t < 150; t++) begin
            send_rand(5'($urandom), cyc);
            if ($urandom_range(0, 4) == 0) idle(1);
        end
        or_mode = 0;
        idle(4);

        // Reset while two ops are held.
        or_mode = 3;
        idle(2);
        send(4'd0, 2'd0, 32'd10, 32'd20, 32'd0, 32'd0, 8'd0, 1'b0, 5'd21, cyc);
        send(4'd2, 2'd0, 32'hF0, 32'h0F, 32'd0, 32'd0, 8'd0, 1'b0, 5'd22, cyc);
        chk("held_two_not_ready", i_ready, 0);
        chk("held_two_valid", o_valid, 1);
        dut_tags.delete();
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
        chk("post_rst_o_valid", o_valid, 0);
        chk("post_rst_o_wdata", o_wdata, 0);
        chk("post_rst_o_tag", o_tag, 0);
        chk("post_rst_i_ready", i_ready, 1);
        or_mode = 0;
        idle(4);
        chk("post_rst_no_output", dut_tags.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog_timeout actual=running expected=finished");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/qpu_exu_alu_rglr_pipe.md
# qpu_exu_alu_rglr_pipe

Parametrised, registered successor of the QPU regular ALU. It accepts one classical/timing ALU operation per cycle over a valid/ready handshake and selects operand 1 from rs1, zero, the timing clock or an indexed qubit-measure result. It adds shift and compare operations and a signed-overflow flag to the existing ALU functions. Results are returned through an output register backed by a one-entry skid buffer, so throughput is one operation per cycle under back-pressure. The block sits in the QPU EXU between dispatch and the write-back arbiter, and owns its datapath instead of sharing one.

## Interface
- XLEN, 32: datapath width; power of 2, ≥ 8.
- TIME_WIDTH, 32: timing clock width; ≤ XLEN.
- QMR_NUM, 8: number of measurement-result bits; power of 2, ≥ 2. QIDX = log2(QMR_NUM).
- TAG_W, 5: width of the destination/ROB tag carried alongside each operation.

- clk  in  1  clock.
- rst  in  1  asynchronous, active-high reset.
- i_valid  in  1  request valid.
- i_ready  out  1  request ready.
- i_rs1, i_rs2, i_imm  in  XLEN  source operands.
- i_clk  in  TIME_WIDTH  current timing-clock value.
- i_qmr  in  QMR_NUM  measurement-result vector.
- i_op  in  4  operation: 0 ADD, 1 SUB, 2 XOR, 3 OR, 4 AND, 5 SLL, 6 SRL, 7 SRA, 8 SLT, 9 SLTU, 10 PASS2; 11–15 illegal.
- i_op1sel  in  2  operand-1 source: 0 rs1, 1 zero, 2 clk, 3 qmr.
- i_op2imm  in  1  operand 2 = i_imm when 1, else i_rs2.
- i_tag  in  TAG_W  tag, returned unchanged.
- o_valid  out  1  result valid.
- o_ready  in  1  result ready.
- o_wdata  out  XLEN  result.
- o_tag  out  TAG_W  tag of the result.
- o_ovf  out  1  signed overflow; meaningful for ADD and SUB only.
- o_illegal  out  1  op code was 11–15.

## Operation
- Operand 1 (a):
  - rs1 (sel 0).
  - All zeros (sel 1).
  - {0, i_clk} zero-extended (sel 2).
  - {0, i_qmr[i_rs1[QIDX-1:0]]} (sel 3); the upper bits of rs1 are ignored.
- Operand 2 (b): i_op2imm ? i_imm : i_rs2.
- ADD/SUB wrap modulo 2^XLEN.
  - ADD overflow: a[MSB] == b[MSB] and res[MSB] != a[MSB].
  - SUB overflow: a[MSB] != b[MSB] and res[MSB] != a[MSB].
  - o_ovf = 0 for all other ops.
- Shifts use b[log2(XLEN)-1:0]. SRA replicates a[MSB].
- SLT is signed and SLTU is unsigned. Both produce 1 or 0, zero-extended.
- PASS2 produces b.
- Illegal ops produce o_wdata = 0 and o_illegal = 1. The operation still completes normally.
- Storage is two entries, each holding {wdata, tag, ovf, illegal}: main (drives outputs) and skid.
  - i_ready = !skid_valid (registered, no combinational path from o_ready).
  - Accept: i_valid & i_ready. Drain: o_valid & o_ready.
  - Main empty, or main draining while skid is empty: an accepted op loads main.
  - Main full, not draining, and accept: the op loads skid.
  - Drain while skid is full: skid moves to main, and skid empties.
  - Order is strictly FIFO; no op is dropped or duplicated.
- Reset (asserted at any time, including mid-operation) clears both entries.
  - o_valid = 0, o_wdata = 0, o_tag = 0, o_ovf = 0, o_illegal = 0.
  - skid_valid = 0, so i_ready = 1 during and after reset.

## Timing
- Latency: an op accepted at edge N is presented on o_valid/o_wdata from after edge N (cycle N+1).
- Sustained throughput is 1 op/cycle while o_ready = 1.
- o_ready low for one cycle with continuous input:
  - At most one op is captured in skid.
  - i_ready drops the following cycle and returns 1 the cycle after skid drains.
- Outputs are stable while o_valid = 1 and o_ready = 0.
- Simultaneous accept and drain with skid empty: main is replaced in the same edge; o_valid stays 1.
- Simultaneous accept and drain with skid full: cannot occur, because i_ready = 0.
- No combinational path from i_* to o_*. The only combinational input-to-output path is none: i_ready is a register output.

## Test plan
- Reset mid-stream with two ops held (o_ready = 0) → after rst, o_valid = 0, all outputs 0, i_ready = 1; neither op appears.
- XLEN = 32, ADD a = 0x7FFFFFFF, b = 1 → o_wdata = 0x80000000, o_ovf = 1. SUB 0x80000000 − 1 → 0x7FFFFFFF, o_ovf = 1. SLT 0xFFFFFFFF vs 1 → 1; SLTU → 0.
- Operand select with op = ADD, i_op2imm = 1, i_imm = 3:
  - sel 2, i_clk = 100 → 103.
  - sel 3, i_qmr = 8'b0010_0000, i_rs1 = 0x25 → 4.
  - sel 1 → 3.
- SRA a = 0x80000000, b = 0x24 → 0xF8000000. op = 12 → o_wdata = 0, o_illegal = 1, tag preserved.
- Back-pressure: 6 back-to-back ops with tags 0–5; o_ready toggles 1,0,0,1,0,1,1,… → tags emerge 0–5 in order, i_ready low exactly while skid is full, no loss.
- Full throughput: 64 random ops with o_ready = 1 → one result per cycle, latency 1, all results matching a reference model.
